// File: rtl/fifo_pkg.sv
// Shared definitions for the 32-entry synchronous FIFO and its drain-side controller.
package fifo_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int FIFO_DEPTH = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } rd_state_t;
endpackage

// File: rtl/fifo_rd_obuf.sv
// Small circular output buffer for the FIFO drain controller.
// The caller never writes when full and never pops when empty; clr has priority.
module fifo_rd_obuf #(
    parameter  int DATA_W    = 8,
    parameter  int BUF_DEPTH = 2,
    localparam int PW        = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int CW        = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    input  logic              clr,
    output logic [CW-1:0]     cnt,
    output logic [DATA_W-1:0] head_data
);
    logic [DATA_W-1:0] mem [BUF_DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    // Explicit wrap so non-power-of-two depths stay in range.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clr) begin
            head <= '0;
            tail <= '0;
            cnt  <= '0;
        end else begin
            if (wr) begin
                mem[tail] <= wdata;
                tail      <= ptr_next(tail);
            end
            if (pop) begin
                head <= ptr_next(head);
            end
            cnt <= cnt + CW'(wr) - CW'(pop);
        end
    end

    assign head_data = mem[head];
endmodule

// File: rtl/fifo_rd_ctrl.sv
// Drain-side controller: pops the FIFO into a valid/ready stream, with enable and flush.
// Define FIFO_RD_STATS_EN to add the word_cnt/stall_cnt statistics outputs.
//
// state | meaning
// IDLE  | no new FIFO reads; buffered and in-flight words still drain
// RUN   | read FIFO whenever the buffer has room for the returning word
// FLUSH | read and discard until FIFO empty and nothing in flight
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BUF_DEPTH = 2,
    parameter int STAT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              flush,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              fifo_rd,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              busy,
    output logic              flush_done
`ifdef FIFO_RD_STATS_EN
    ,
    output logic [STAT_W-1:0] word_cnt,
    output logic [STAT_W-1:0] stall_cnt
`endif
);
    localparam int CW = $clog2(BUF_DEPTH + 1);

    rd_state_t     state;
    rd_state_t     state_nxt;
    logic          rd_q;
    logic [CW-1:0] cnt;
    logic [CW:0]   occ;
    logic          pop;
    logic          flush_entry;
    logic          clr;
    logic          wr;

    assign m_valid     = (cnt != '0);
    assign pop         = m_valid & m_ready;
    assign flush_entry = flush & (state != FLUSH);
    assign clr         = flush_entry | (state == FLUSH);
    // The word returning from a read issued during flush is dropped here.
    assign wr          = rd_q & ~clr;
    // Slots that will be occupied once the in-flight word lands and this cycle's pop retires.
    assign occ         = (CW+1)'(cnt) + (CW+1)'(rd_q) - (CW+1)'(pop);
    assign busy        = (state != IDLE) | m_valid | rd_q;

    always_comb begin
        state_nxt  = state;
        fifo_rd    = 1'b0;
        flush_done = 1'b0;
        case (state)
            IDLE: begin
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (en) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                fifo_rd = en & ~fifo_empty & (occ < (CW+1)'(BUF_DEPTH));
                if (flush) begin
                    state_nxt = FLUSH;
                end else if (!en) begin
                    state_nxt = IDLE;
                end
            end
            FLUSH: begin
                fifo_rd = ~fifo_empty;
                if (fifo_empty && !rd_q) begin
                    flush_done = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            rd_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q  <= fifo_rd;
        end
    end

    fifo_rd_obuf #(
        .DATA_W   (DATA_W),
        .BUF_DEPTH(BUF_DEPTH)
    ) u_obuf (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr       (wr),
        .wdata    (fifo_rdata),
        .pop      (pop),
        .clr      (clr),
        .cnt      (cnt),
        .head_data(m_data)
    );

`ifdef FIFO_RD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else if (flush_entry) begin
            word_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (pop && word_cnt != '1) begin
                word_cnt <= word_cnt + 1'b1;
            end
            if (m_valid && !m_ready && stall_cnt != '1) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl with a behavioural 32-entry FIFO (registered read).
// Statistics checks are compiled in when FIFO_RD_STATS_EN is defined.
module tb_fifo_rd_ctrl;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          flush = 1'b0;
    logic          fifo_empty;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          busy;
    logic          flush_done;
`ifdef FIFO_RD_STATS_EN
    logic [15:0]   word_cnt;
    logic [15:0]   stall_cnt;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .flush     (flush),
        .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata),
        .fifo_rd   (fifo_rd),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .busy      (busy),
        .flush_done(flush_done)
`ifdef FIFO_RD_STATS_EN
        ,
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Behavioural FIFO: push from the bench, pop on fifo_rd, data one cycle later.
    logic [DW-1:0] fmem [32];
    int            wp = 0;
    int            rp = 0;
    int            fcnt = 0;
    int            rd_on_empty = 0;
    logic          push_v = 1'b0;
    logic [DW-1:0] push_d = '0;
    logic          fifo_clr = 1'b0;

    always @(posedge clk) begin
        if (fifo_clr) begin
            wp   <= 0;
            rp   <= 0;
            fcnt <= 0;
        end else begin
            if (fifo_rd && fcnt != 0) begin
                fifo_rdata <= fmem[rp];
                rp         <= (rp + 1) % 32;
            end
            if (fifo_rd && fcnt == 0) begin
                rd_on_empty <= rd_on_empty + 1;
            end
            if (push_v) begin
                fmem[wp] <= push_d;
                wp       <= (wp + 1) % 32;
            end
            fcnt <= fcnt + (push_v ? 1 : 0) - ((fifo_rd && fcnt != 0) ? 1 : 0);
        end
    end

    assign fifo_empty = (fcnt == 0);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] d);
        push_d = d;
        push_v = 1'b1;
        @(negedge clk);
        push_v = 1'b0;
    endtask

    initial begin
        int            rd_cnt;
        int            got;
        int            vld_cnt;
        int            done_cnt;
        int            hold_bad;
        logic [DW-1:0] exp_w [5];
        logic [DW-1:0] last_w;

        // Reset values while rst_n is held low
        @(negedge clk);
        chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_data", 32'(m_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush_done", 32'(flush_done), 32'd0);
`ifdef FIFO_RD_STATS_EN
        chk("rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // 1: three words, consumer always ready, latency 2, one word per cycle
        push(8'h11);
        push(8'h22);
        push(8'h33);
        en = 1'b1;
        m_ready = 1'b1;
        chk("t1_idle_rd", 32'(fifo_rd), 32'd0);
        @(negedge clk);
        chk("t1_rd_c1", 32'(fifo_rd), 32'd1);
        @(negedge clk);
        chk("t1_rd_c2", 32'(fifo_rd), 32'd1);
        chk("t1_valid_c2", 32'(m_valid), 32'd0);
        @(negedge clk);
        chk("t1_rd_c3", 32'(fifo_rd), 32'd1);
        chk("t1_valid_c3", 32'(m_valid), 32'd1);
        chk("t1_data_c3", 32'(m_data), 32'h11);
        @(negedge clk);
        chk("t1_rd_c4", 32'(fifo_rd), 32'd0);
        chk("t1_valid_c4", 32'(m_valid), 32'd1);
        chk("t1_data_c4", 32'(m_data), 32'h22);
        @(negedge clk);
        chk("t1_valid_c5", 32'(m_valid), 32'd1);
        chk("t1_data_c5", 32'(m_data), 32'h33);
        en = 1'b0;
        @(negedge clk);
        chk("t1_valid_end", 32'(m_valid), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);

        // 2: five words, consumer stalled -> buffer fills with 2, then drains in order
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            exp_w[i] = 8'hA1 + 8'(i);
            push(exp_w[i]);
        end
        en = 1'b1;
        rd_cnt = 0;
        hold_bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fifo_rd) rd_cnt++;
            if (m_valid && m_data !== 8'hA1) hold_bad++;
        end
        chk("t2_rd_pulses", 32'(rd_cnt), 32'd2);
        chk("t2_hold_valid", 32'(m_valid), 32'd1);
        chk("t2_hold_data", 32'(m_data), 32'hA1);
        chk("t2_hold_stable", 32'(hold_bad), 32'd0);
        m_ready = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && got < 5; i++) begin
            if (m_valid) begin
                chk($sformatf("t2_word%0d", got), 32'(m_data), 32'(exp_w[got]));
                got++;
            end
            @(negedge clk);
        end
        chk("t2_word_count", 32'(got), 32'd5);
        vld_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (m_valid) vld_cnt++;
            @(negedge clk);
        end
        chk("t2_no_dup", 32'(vld_cnt), 32'd0);
        chk("t2_fifo_left", 32'(fcnt), 32'd0);
        en = 1'b0;

        // 3: empty FIFO never read; one pushed word read exactly once
        @(negedge clk);
        en = 1'b1;
        rd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fifo_rd) rd_cnt++;
        end
        chk("t3_rd_on_empty", 32'(rd_cnt), 32'd0);
        push(8'hA5);
        rd_cnt = 0;
        vld_cnt = 0;
        last_w = '0;
        for (int i = 0; i < 6; i++) begin
            if (fifo_rd) rd_cnt++;
            if (m_valid) begin
                vld_cnt++;
                last_w = m_data;
            end
            @(negedge clk);
        end
        chk("t3_single_rd", 32'(rd_cnt), 32'd1);
        chk("t3_single_valid", 32'(vld_cnt), 32'd1);
        chk("t3_data", 32'(last_w), 32'hA5);
        en = 1'b0;

        // 4: flush with 8 words in the FIFO and 2 buffered
        m_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            push(8'h40 + 8'(i));
        end
        en = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_pre_valid", 32'(m_valid), 32'd1);
        chk("t4_pre_fcnt", 32'(fcnt), 32'd8);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t4_valid_drop", 32'(m_valid), 32'd0);
        chk("t4_busy", 32'(busy), 32'd1);
        done_cnt = 0;
        vld_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (flush_done) done_cnt++;
            if (m_valid) vld_cnt++;
            @(negedge clk);
        end
        chk("t4_done_once", 32'(done_cnt), 32'd1);
        chk("t4_no_emit", 32'(vld_cnt), 32'd0);
        chk("t4_fifo_empty", 32'(fcnt), 32'd0);
        en = 1'b0;
        @(negedge clk);

        // 5: en drops with one word buffered and one in flight
        m_ready = 1'b0;
        push(8'hB1);
        push(8'hB2);
        push(8'hB3);
        en = 1'b1;
        @(negedge clk);
        chk("t5_rd_c1", 32'(fifo_rd), 32'd1);
        @(negedge clk);
        chk("t5_rd_c2", 32'(fifo_rd), 32'd1);
        @(negedge clk);
        chk("t5_rd_c3", 32'(fifo_rd), 32'd0);
        en = 1'b0;
        @(negedge clk);
        m_ready = 1'b1;
        rd_cnt = 0;
        got = 0;
        for (int i = 0; i < 8; i++) begin
            if (fifo_rd) rd_cnt++;
            if (m_valid) begin
                chk($sformatf("t5_word%0d", got), 32'(m_data), (got == 0) ? 32'hB1 : 32'hB2);
                got++;
            end
            @(negedge clk);
        end
        chk("t5_word_count", 32'(got), 32'd2);
        chk("t5_no_rd", 32'(rd_cnt), 32'd0);
        chk("t5_busy_idle", 32'(busy), 32'd0);
        chk("t5_fifo_left", 32'(fcnt), 32'd1);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;

`ifdef FIFO_RD_STATS_EN
        // 6: statistics -- 4 pops and 3 stall cycles, cleared by flush
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        @(negedge clk);
        chk("t6_word_clr", 32'(word_cnt), 32'd0);
        chk("t6_stall_clr", 32'(stall_cnt), 32'd0);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(8'hC1 + 8'(i));
        end
        en = 1'b1;
        for (int i = 0; i < 10 && !m_valid; i++) begin
            @(negedge clk);
        end
        chk("t6_valid_seen", 32'(m_valid), 32'd1);
        repeat (3) @(negedge clk);
        m_ready = 1'b1;
        repeat (12) @(negedge clk);
        en = 1'b0;
        chk("t6_word_cnt", 32'(word_cnt), 32'd4);
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd3);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("t6_word_flush", 32'(word_cnt), 32'd0);
        chk("t6_stall_flush", 32'(stall_cnt), 32'd0);
        @(negedge clk);
`endif

        // 7: asynchronous reset in the middle of a burst
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push(8'hD1 + 8'(i));
        end
        en = 1'b1;
        repeat (3) @(negedge clk);
        chk("t7_pre_valid", 32'(m_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("t7_rst_fifo_rd", 32'(fifo_rd), 32'd0);
        chk("t7_rst_m_valid", 32'(m_valid), 32'd0);
        chk("t7_rst_m_data", 32'(m_data), 32'd0);
        chk("t7_rst_busy", 32'(busy), 32'd0);
        chk("t7_rst_flush_done", 32'(flush_done), 32'd0);
`ifdef FIFO_RD_STATS_EN
        chk("t7_rst_word_cnt", 32'(word_cnt), 32'd0);
        chk("t7_rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        @(negedge clk);
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t7_post_busy", 32'(busy), 32'd0);
        chk("rd_while_empty", 32'(rd_on_empty), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
